// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: times mid-bit samples after a start-bit pulse,
// shifts in data LSB first, checks parity/stop and strobes the received word.
module uart_rx_deserializer #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_ODD       = 0,
`ifdef FORMAL
    parameter int CLOCKS_PER_BIT   = 8
`else
    parameter int CLOCKS_PER_BIT   = 5000
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        serial_in_synced,
    input  logic                        start_detected,
    output logic [INPUT_DATA_WIDTH-1:0] data_out,
    output logic                        data_valid,
    output logic                        parity_error,
    output logic                        framing_error,
    output logic                        busy
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(INPUT_DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLOCKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(INPUT_DATA_WIDTH - 1);
    localparam logic             PAR_EN   = (PARITY_ENABLED != 0);
    localparam logic             PAR_ODD  = (PARITY_ODD != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]                  state;
    logic [CNT_W-1:0]            clk_cnt;
    logic [BIT_W-1:0]            bit_cnt;
    logic [INPUT_DATA_WIDTH-1:0] shift_reg;
    logic                        parity_err_r;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_err_r  <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Counter starts at 1 so the START sample lands exactly HALF edges after T
                    if (start_detected) begin
                        state   <= START;
                        clk_cnt <= CNT_W'(1);
                    end
                end
                START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        state   <= serial_in_synced ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt   <= '0;
                        shift_reg <= {serial_in_synced, shift_reg[INPUT_DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= PAR_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt      <= '0;
                        parity_err_r <= serial_in_synced ^ (^shift_reg) ^ PAR_ODD;
                        state        <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt       <= '0;
                        data_out      <= shift_reg;
                        parity_error  <= PAR_EN & parity_err_r;
                        framing_error <= ~serial_in_synced;
                        data_valid    <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: one parity-enabled and one
// parity-less instance, frames driven bit-by-bit relative to the start edge T.
module tb_uart_rx_deserializer;

    logic       clk;
    logic       rst_n;
    logic       serial_a, start_a, serial_b, start_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, pe_a, fe_a, busy_a;
    logic       valid_b, pe_b, fe_b, busy_b;

    int tests_run;
    int tests_failed;

    uart_rx_deserializer #(
        .INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .PARITY_ODD(0), .CLOCKS_PER_BIT(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .serial_in_synced(serial_a), .start_detected(start_a),
        .data_out(data_a), .data_valid(valid_a), .parity_error(pe_a),
        .framing_error(fe_a), .busy(busy_a)
    );

    uart_rx_deserializer #(
        .INPUT_DATA_WIDTH(8), .PARITY_ENABLED(0), .PARITY_ODD(0), .CLOCKS_PER_BIT(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .serial_in_synced(serial_b), .start_detected(start_b),
        .data_out(data_b), .data_valid(valid_b), .parity_error(pe_b),
        .framing_error(fe_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one frame: bits[i] is held for the 8 edges T+8i..T+8i+7 (start bit is bits[0]).
    // force_low overrides the line to 0 for edges T..T+force_low-1 (glitch stimulus).
    // extra_pulse / rst_at: edge offsets for a spurious start pulse / reset pulse (-1 = none).
    task automatic run_frame(input int dut, input logic [11:0] bits, input int force_low,
                             input int extra_pulse, input int rst_at,
                             output int valid_cnt, output int valid_edge,
                             output logic [7:0] d, output logic pe, output logic fe,
                             output int busy_fall);
        logic line;
        logic [11:0] b;
        valid_cnt  = 0;
        valid_edge = -1;
        busy_fall  = -1;
        d  = 'x;
        pe = 1'bx;
        fe = 1'bx;
        b  = bits;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n < force_low) line = 1'b0;
            else if (n / 8 < 12) line = b[n / 8];
            else line = 1'b1;
            if (dut == 0) begin
                serial_a = line;
                start_a  = (n == 0 || n == extra_pulse);
            end else begin
                serial_b = line;
                start_b  = (n == 0 || n == extra_pulse);
            end
            rst_n = (n == rst_at) ? 1'b0 : 1'b1;
            if (n == rst_at) begin
                #1;
                tests_run++;
                if ({data_a, valid_a, pe_a, fe_a, busy_a} !== 12'h000) begin
                    tests_failed++;
                    $display("FAIL reset_midframe: outputs {data,valid,pe,fe,busy}=%h required 000",
                             {data_a, valid_a, pe_a, fe_a, busy_a});
                end
            end
            @(posedge clk);
            #1;
            if (dut == 0) begin
                if (valid_a) begin
                    valid_cnt++;
                    valid_edge = n;
                    d  = data_a;
                    pe = pe_a;
                    fe = fe_a;
                end
                if (!busy_a && busy_fall < 0) busy_fall = n;
            end else begin
                if (valid_b) begin
                    valid_cnt++;
                    valid_edge = n;
                    d  = data_b;
                    pe = pe_b;
                    fe = fe_b;
                end
                if (!busy_b && busy_fall < 0) busy_fall = n;
            end
        end
        @(negedge clk);
        serial_a = 1'b1;
        serial_b = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        serial_a = 1'b1; serial_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({data_a, valid_a, pe_a, fe_a, busy_a} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_a: {data,valid,pe,fe,busy}=%h required 000",
                     {data_a, valid_a, pe_a, fe_a, busy_a});
        end
        tests_run++;
        if ({data_b, valid_b, pe_b, fe_b, busy_b} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_b: {data,valid,pe,fe,busy}=%h required 000",
                     {data_b, valid_b, pe_b, fe_b, busy_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Common checker for a single expected data_valid.
    task automatic test_frame(input string name, input int dut, input logic [11:0] bits,
                              input int extra_pulse, input int exp_edge,
                              input logic [7:0] exp_d, input logic exp_pe, input logic exp_fe);
        int vc, ve, bf;
        logic [7:0] d;
        logic pe, fe;
        run_frame(dut, bits, 0, extra_pulse, -1, vc, ve, d, pe, fe, bf);
        tests_run++;
        if (vc !== 1 || ve !== exp_edge) begin
            tests_failed++;
            $display("FAIL %s_valid: count=%0d edge=T+%0d required count=1 edge=T+%0d",
                     name, vc, ve, exp_edge);
        end
        tests_run++;
        if (d !== exp_d) begin
            tests_failed++;
            $display("FAIL %s_data: got %h required %h", name, d, exp_d);
        end
        tests_run++;
        if ({pe, fe} !== {exp_pe, exp_fe}) begin
            tests_failed++;
            $display("FAIL %s_flags: pe,fe=%b%b required %b%b", name, pe, fe, exp_pe, exp_fe);
        end
        tests_run++;
        if (bf !== exp_edge) begin
            tests_failed++;
            $display("FAIL %s_busy: busy fell at T+%0d required T+%0d", name, bf, exp_edge);
        end
    endtask

    // bits: {idle, stop, parity, data[7:0], start}
    task automatic test_good_frame();
        test_frame("good_a5", 0, {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}, -1, 84, 8'hA5, 1'b0, 1'b0);
        test_frame("odd_ones_07", 0, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, -1, 84, 8'h07, 1'b0, 1'b0);
    endtask

    task automatic test_parity_error();
        test_frame("parity_a5", 0, {1'b1, 1'b1, 1'b1, 8'hA5, 1'b0}, -1, 84, 8'hA5, 1'b1, 1'b0);
    endtask

    task automatic test_framing_error();
        test_frame("framing_3c", 0, {1'b1, 1'b0, 1'b0, 8'h3C, 1'b0}, -1, 84, 8'h3C, 1'b0, 1'b1);
    endtask

    task automatic test_false_start();
        int vc, ve, bf;
        logic [7:0] d;
        logic pe, fe;
        run_frame(0, 12'hFFF, 2, -1, -1, vc, ve, d, pe, fe, bf);
        tests_run++;
        if (vc !== 0) begin
            tests_failed++;
            $display("FAIL false_start_valid: %0d strobes required 0", vc);
        end
        tests_run++;
        if (bf !== 4) begin
            tests_failed++;
            $display("FAIL false_start_busy: busy fell at T+%0d required T+4", bf);
        end
        tests_run++;
        if (data_a !== 8'h3C || fe_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL false_start_hold: data=%h fe=%b required 3c 1", data_a, fe_a);
        end
    endtask

    task automatic test_back_to_back();
        test_frame("restart_c3", 0, {1'b1, 1'b1, 1'b0, 8'hC3, 1'b0}, 30, 84, 8'hC3, 1'b0, 1'b0);
        // parity-less instance: stop bit sits in slot 9
        test_frame("nopar_ff", 1, {1'b1, 1'b1, 1'b1, 8'hFF, 1'b0}, 30, 76, 8'hFF, 1'b0, 1'b0);
        test_frame("nopar_stop0", 1, {1'b1, 1'b1, 1'b0, 8'h81, 1'b0}, -1, 76, 8'h81, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        int vc, ve, bf;
        logic [7:0] d;
        logic pe, fe;
        run_frame(0, {1'b1, 1'b1, 1'b0, 8'h5A, 1'b0}, 0, -1, 40, vc, ve, d, pe, fe, bf);
        tests_run++;
        if (vc !== 0) begin
            tests_failed++;
            $display("FAIL reset_midframe_valid: %0d strobes required 0", vc);
        end
        test_frame("after_reset_5a", 0, {1'b1, 1'b1, 1'b0, 8'h5A, 1'b0}, -1, 84, 8'h5A, 1'b0, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_false_start();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
